// File: rtl/keypad_row_decoder.sv
// rtl/keypad_row_decoder.sv - 4x4 keypad row sense, debounce and key decode
// Freezes the scan column via en while a candidate or accepted key is present.
module keypad_row_decoder #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_W           = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] columna,
  input  logic [3:0] filas,
  output logic       en,
  output logic [3:0] key_code,
  output logic       key_valid
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       rows_q, rows_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       row_cap_q, row_cap_d;
  logic [1:0]       col_cap_q, col_cap_d;
  logic             en_q, en_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;

  logic             rows_one_hot;
  logic [1:0]       row_idx;

  assign rows_one_hot = (rows_q != 4'd0) && ((rows_q & (rows_q - 4'd1)) == 4'd0);

  always_comb begin
    row_idx = 2'd0;
    case (row_cap_q)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sync1_d     = filas;
    rows_d      = sync1_q;
    cnt_d       = cnt_q;
    row_cap_d   = row_cap_q;
    col_cap_d   = col_cap_q;
    en_d        = en_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (rows_one_hot) begin
          row_cap_d = rows_q;
          col_cap_d = columna;
          cnt_d     = '0;
          state_d   = DEBOUNCE;
          en_d      = 1'b1;
        end
      end
      DEBOUNCE: begin
        en_d = 1'b1;
        // A column advance racing the detection also lands here as a mismatch.
        if (rows_q != row_cap_q || columna != col_cap_q) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = PRESSED;
          key_code_d  = {row_idx, col_cap_q};
          key_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        en_d = 1'b1;
        if (rows_q == 4'd0) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        en_d = 1'b1;
        if (rows_q != 4'd0) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync1_q     <= 4'd0;
      rows_q      <= 4'd0;
      cnt_q       <= '0;
      row_cap_q   <= 4'd0;
      col_cap_q   <= 2'd0;
      en_q        <= 1'b0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rows_q      <= rows_d;
      cnt_q       <= cnt_d;
      row_cap_q   <= row_cap_d;
      col_cap_q   <= col_cap_d;
      en_q        <= en_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign en        = en_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_row_decoder.sv
// tb/tb_keypad_row_decoder.sv - randomized bench for keypad_row_decoder
// Reference model tracks press/release phases by counting stable sampled cycles.
module tb_keypad_row_decoder;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] columna;
  logic [3:0] filas;
  logic       en;
  logic [3:0] key_code;
  logic       key_valid;

  keypad_row_decoder #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .columna  (columna),
    .filas    (filas),
    .en       (en),
    .key_code (key_code),
    .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int kv_seen = 0;

  // 0 waiting, 1 qualifying a press, 2 key held, 3 qualifying a release
  int         m_phase;
  int         m_stable;
  logic [3:0] m_s1, m_s2, m_row, m_code;
  logic [1:0] m_col;
  logic       m_kv;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_stable = 0;
    m_s1 = 4'd0; m_s2 = 4'd0; m_row = 4'd0; m_col = 2'd0;
    m_code = 4'd0; m_kv = 1'b0;
  endtask

  function automatic logic [1:0] row_number(input logic [3:0] r);
    logic [1:0] n = 2'd0;
    for (int i = 0; i < 4; i++) if (r[i]) n = 2'(i);
    return n;
  endfunction

  task automatic model_edge(input logic [3:0] f, input logic [1:0] c);
    logic [3:0] rs = m_s2;
    m_kv = 1'b0;
    case (m_phase)
      0: if ($countones(rs) == 1) begin
           m_row = rs; m_col = c; m_stable = 0; m_phase = 1;
         end
      1: if (rs != m_row || c != m_col) m_phase = 0;
         else begin
           m_stable++;
           if (m_stable == D) begin
             m_phase = 2; m_code = {row_number(m_row), m_col}; m_kv = 1'b1;
           end
         end
      2: if (rs == 4'd0) begin m_stable = 0; m_phase = 3; end
      default: if (rs != 4'd0) m_phase = 2;
               else begin
                 m_stable++;
                 if (m_stable == D) m_phase = 0;
               end
    endcase
    m_s2 = m_s1;
    m_s1 = f;
  endtask

  task automatic step(input logic [3:0] f, input logic [1:0] c);
    filas = f; columna = c;
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge(f, c);
    @(negedge clk);
    if (key_valid) kv_seen++;
    check("en", {3'd0, en}, {3'd0, m_phase != 0});
    check("key_valid", {3'd0, key_valid}, {3'd0, m_kv});
    check("key_code", key_code, m_code);
  endtask

  task automatic hold(input logic [3:0] f, input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) step(f, c);
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check({tag, "_en"}, {3'd0, en}, 4'd0);
    check({tag, "_kv"}, {3'd0, key_valid}, 4'd0);
    check({tag, "_code"}, key_code, 4'd0);
    @(negedge clk);
    hold(4'b0100, 2'd1, 2);
    reset = 1'b1;
  endtask

  initial begin
    int kind, len;
    logic [3:0] f;
    logic [1:0] c;
    model_reset();
    reset = 1'b0; filas = 4'b1011; columna = 2'd3;
    #1;
    check("rst_en", {3'd0, en}, 4'd0);
    check("rst_code", key_code, 4'd0);
    hold(4'b0110, 2'd1, 3);
    reset = 1'b1;
    hold(4'd0, 2'd0, 4);

    kv_seen = 0;
    hold(4'b0100, 2'd2, 3);
    check("en_after_3", {3'd0, en}, 4'd1);
    hold(4'b0100, 2'd2, 117);
    check("clean_code", key_code, 4'hA);
    check("clean_pulses", 4'(kv_seen), 4'd1);
    hold(4'd0, 2'd2, D + 4);

    kv_seen = 0;
    hold(4'b0001, 2'd0, 5);
    hold(4'd0, 2'd0, 10);
    check("bounce_pulses", 4'(kv_seen), 4'd0);
    check("bounce_code", key_code, 4'hA);

    hold(4'b0001, 2'd1, D + 6);
    kv_seen = 0;
    hold(4'd0, 2'd1, 8);
    hold(4'b0001, 2'd1, 4);
    hold(4'd0, 2'd1, 20);
    check("relbounce_pulses", 4'(kv_seen), 4'd0);
    check("relbounce_code", key_code, 4'h1);

    hold(4'b0011, 2'd2, 10);
    check("multi_en", {3'd0, en}, 4'd0);
    hold(4'b1000, 2'd2, 6);
    hold(4'b1000, 2'd3, 6);
    hold(4'd0, 2'd3, 4);

    hold(4'b0010, 2'd0, 8);
    async_reset_check("rst_deb");
    hold(4'd0, 2'd0, 3);
    hold(4'b1000, 2'd3, D + 8);
    async_reset_check("rst_pressed");
    hold(4'd0, 2'd0, 3);

    for (int s = 0; s < 120; s++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 40);
      c    = 2'($urandom_range(0, 3));
      if (kind < 2) f = 4'd0;
      else if (kind < 7) f = 4'd1 << $urandom_range(0, 3);
      else if (kind == 7) f = 4'b0101 << $urandom_range(0, 1);
      else f = 4'($urandom_range(0, 15));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 29) == 0) c = 2'($urandom_range(0, 3));
        step(f, c);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
